// File: rtl/rom_burst_reader.sv
// rom_burst_reader: walks a combinational ROM from a start address for a
// programmable number of words and presents each word on a registered
// valid/ready stream, tagging the final word and pulsing done on its hand-off.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no burst; waiting for start (abort has priority over start)
// ST_RUN   | words still to fetch; loads a new word whenever the slot frees
// ST_DRAIN | final word is loaded; waiting for the consumer to take it

module rom_burst_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [ADDR_W:0]   i_burst_len,
    input  logic              i_abort,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_last,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // A zero length encodes a full-depth burst, so the counter is one bit
    // wider than the address.
    localparam logic [ADDR_W:0] REM_ZERO = '0;
    localparam logic [ADDR_W:0] REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] REM_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_remain;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_last;
    logic                r_done;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [ADDR_W:0]     w_remain_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                w_valid_nxt;
    logic                w_last_nxt;
    logic                w_done_nxt;

    logic                w_load;
    logic                w_accept;

    // The output slot can take a new word when empty or being emptied this cycle.
    assign w_load   = (!r_valid || i_out_ready) && (r_remain != REM_ZERO);
    assign w_accept = r_valid && i_out_ready;

    // State and datapath registers; everything clears on reset, including in-flight words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_remain <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_remain <= w_remain_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
            r_last   <= w_last_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next-state and datapath updates; abort overrides everything in an active burst.
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_remain_nxt = r_remain;
        w_data_nxt   = r_data;
        w_valid_nxt  = r_valid;
        w_last_nxt   = r_last;
        w_done_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_addr_nxt   = i_start_addr;
                    w_remain_nxt = (i_burst_len == REM_ZERO) ? REM_FULL : i_burst_len;
                    w_state_nxt  = ST_RUN;
                end
            end

            ST_RUN: begin
                if (i_abort) begin
                    w_state_nxt  = ST_IDLE;
                    w_valid_nxt  = 1'b0;
                    w_last_nxt   = 1'b0;
                    w_remain_nxt = REM_ZERO;
                end else if (w_load) begin
                    w_data_nxt   = i_rom_data;
                    w_valid_nxt  = 1'b1;
                    w_last_nxt   = (r_remain == REM_ONE);
                    w_addr_nxt   = r_addr + 1'b1;
                    w_remain_nxt = r_remain - 1'b1;
                    if (r_remain == REM_ONE) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end else if (w_accept) begin
                    w_valid_nxt = 1'b0;
                end
            end

            ST_DRAIN: begin
                if (i_abort) begin
                    w_state_nxt  = ST_IDLE;
                    w_valid_nxt  = 1'b0;
                    w_last_nxt   = 1'b0;
                    w_remain_nxt = REM_ZERO;
                end else if (w_accept) begin
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_valid_nxt  = 1'b0;
                w_last_nxt   = 1'b0;
                w_remain_nxt = REM_ZERO;
            end
        endcase
    end

    assign o_rom_addr  = r_addr;
    assign o_out_data  = r_data;
    assign o_out_valid = r_valid;
    assign o_out_last  = r_last;
    assign o_done      = r_done;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: drives directed and random bursts into rom_burst_reader
// with a one-hot ROM model; expected words go into a queue at start time and a
// negedge monitor pops and compares on every accepted transfer.

module tb_rom_burst_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  start_addr;
    logic [4:0]  burst_len;
    logic        abort;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          n_pop = 0;

    logic        exp_done = 1'b0;
    logic        held     = 1'b0;
    logic [15:0] held_d;
    logic        held_l;

    rom_burst_reader #(.ADDR_W(4), .DATA_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_start_addr (start_addr),
        .i_burst_len  (burst_len),
        .i_abort      (abort),
        .o_rom_addr   (rom_addr),
        .i_rom_data   (rom_data),
        .o_out_data   (out_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_last   (out_last),
        .o_busy       (busy),
        .o_done       (done)
    );

    // One-hot lookup ROM
    assign rom_data = 16'h0001 << rom_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: transfers complete at the next posedge when valid && ready here.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_done = 1'b0;
            held     = 1'b0;
        end else begin
            total++;
            if (done !== exp_done) begin
                bad++;
                $display("FAIL done: got=%b want=%b", done, exp_done);
            end
            exp_done = 1'b0;
            if (!out_valid && out_last) begin
                total++;
                bad++;
                $display("FAIL last_without_valid: got last=1 want last=0");
            end
            if (held && out_valid) begin
                total++;
                if (out_data !== held_d || out_last !== held_l) begin
                    bad++;
                    $display("FAIL stall_hold: got data=%h last=%b want data=%h last=%b",
                             out_data, out_last, held_d, held_l);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_word: got data=%h want no word", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out_data !== e.d || out_last !== e.l) begin
                        bad++;
                        $display("FAIL word: got data=%h last=%b want data=%h last=%b",
                                 out_data, out_last, e.d, e.l);
                    end
                    if (e.l) exp_done = 1'b1;
                end
                n_pop++;
                held = 1'b0;
            end else if (out_valid) begin
                held   = 1'b1;
                held_d = out_data;
                held_l = out_last;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got busy=1 want busy=0 within 500 cycles");
        end
    endtask

    task automatic push_burst(input logic [3:0] a, input logic [4:0] len, output int n);
        logic [15:0] one;
        exp_t        e;
        one = 16'h0001;
        n = (len == 5'd0) ? 16 : int'(len);
        for (int k = 0; k < n; k++) begin
            e.d = one << ((int'(a) + k) % 16);
            e.l = (k == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles after first valid.
    task automatic run_burst(input logic [3:0] a, input logic [4:0] len, input int mode,
                             input int abort_after, input bit poke);
        int          n, cyc, first_v, done_c, base_pop;
        bit          fin, aborted;
        logic [3:0]  a1;
        wait_idle();
        push_burst(a, len, n);
        a1         = a + 4'd1;
        base_pop   = n_pop;
        start      = 1'b1;
        start_addr = a;
        burst_len  = len;
        abort      = 1'b0;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        chk("rom_addr_start", 32'(rom_addr), 32'(a));
        chk("busy_start", 32'(busy), 32'd1);
        first_v = -1;
        done_c  = -1;
        fin     = 1'b0;
        aborted = 1'b0;
        while (!fin && cyc < 300) begin
            if (first_v < 0 && out_valid) first_v = cyc;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (first_v >= 0 && cyc - first_v < 3) ? 1'b0 : 1'b1;
            endcase
            if (mode == 2 && first_v >= 0 && cyc - first_v < 3)
                chk("stall_rom_addr", 32'(rom_addr), 32'(a1));
            if (poke && busy && $urandom_range(0, 3) == 0) begin
                start      = 1'b1;
                start_addr = 4'($urandom_range(0, 15));
                burst_len  = 5'($urandom_range(0, 16));
            end
            if (abort_after >= 0 && busy && (n_pop - base_pop) == abort_after) begin
                abort     = 1'b1;
                out_ready = 1'b0;
                exp_q.delete();
            end
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (abort) begin
                abort   = 1'b0;
                aborted = 1'b1;
                fin     = 1'b1;
                chk("abort_valid", 32'(out_valid), 32'd0);
                chk("abort_last", 32'(out_last), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
            end else if (done) begin
                done_c = cyc;
                fin    = 1'b1;
            end
        end
        out_ready = 1'b1;
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL burst_timeout: got no done/abort want completion within 300 cycles");
        end else begin
            chk("first_valid_cycle", 32'(first_v), 32'd2);
            if (!aborted) begin
                chk("queue_empty", 32'(exp_q.size()), 32'd0);
                chk("busy_after_done", 32'(busy), 32'd0);
                if (mode == 0) chk("done_cycle", 32'(done_c), 32'(n + 2));
            end
        end
    endtask

    task automatic reset_mid();
        int n;
        wait_idle();
        push_burst(4'd7, 5'd12, n);
        start      = 1'b1;
        start_addr = 4'd7;
        burst_len  = 5'd12;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        start      = 1'b1;
        start_addr = 4'd2;
        burst_len  = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        burst_len  = '0;
        abort      = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("init_rom_addr", 32'(rom_addr), 32'd0);
        chk("init_out_data", 32'(out_data), 32'd0);
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_out_last", 32'(out_last), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_done", 32'(done), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_burst(4'd0,  5'd4, 0, -1, 1'b0);
        run_burst(4'd14, 5'd4, 0, -1, 1'b0);
        run_burst(4'd5,  5'd0, 0, -1, 1'b0);
        run_burst(4'd0,  5'd3, 2, -1, 1'b0);
        run_burst(4'd0,  5'd8, 0, 2,  1'b0);
        run_burst(4'd3,  5'd1, 0, -1, 1'b0);
        run_burst(4'd9,  5'd6, 0, -1, 1'b1);
        reset_mid();
        run_burst(4'd11, 5'd5, 1, -1, 1'b1);

        for (int b = 0; b < 30; b++) begin
            logic [3:0] a;
            logic [4:0] len;
            int         n, ab, md;
            a   = 4'($urandom_range(0, 15));
            len = 5'($urandom_range(0, 16));
            n   = (len == 5'd0) ? 16 : int'(len);
            md  = $urandom_range(0, 1);
            ab  = ($urandom_range(0, 3) == 0 && n > 1) ? $urandom_range(1, n - 1) : -1;
            run_burst(a, len, md, ab, 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
